run_length_detector: RTL
========================

Name: run_length_detector

Overview:
- Serial-bit run detector: asserts a flag when the input has held the same value for RUN_LEN consecutive accepted samples. It detects runs of 0s and runs of 1s.
- Generalises the fixed three-in-a-row 0/1 detector FSM:
  - run length is a parameter;
  - adds a sample-enable qualifier;
  - adds a level/pulse (overlapping/non-overlapping) mode;
  - reports which bit value formed the run;
  - keeps a saturating detection-event counter.
- Sits on the serial input path feeding control/status logic.

Parameters:
- RUN_LEN, 3, consecutive equal samples required for detection; legal range 2..255.
- CNT_W, 8, width of the detection-event counter det_cnt.
- RC_W, $clog2(RUN_LEN+1), width of run_cnt (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- en  input  1  sample qualifier; x is accepted only on a clk edge with en=1.
- x  input  1  serial data bit.
- mode  input  1  0 = level (saturating), 1 = pulse (non-overlapping restart).
- clr  input  1  synchronous clear of det_cnt.
- y  output  1  run detected; high when run_cnt == RUN_LEN.
- y_val  output  1  bit value of the current run; valid when y=1, 0 otherwise.
- run_cnt  output  RC_W  length of the current run, 0..RUN_LEN.
- det_cnt  output  CNT_W  number of detection events since reset/clr; saturating.

Behaviour:
- Reset (asynchronous, immediate, any time including mid-run):
  - run_cnt=0, last_bit=0, det_cnt=0, y=0, y_val=0.
- Moore outputs:
  - y, y_val and run_cnt are decoded from registers only, with no combinational path from x.
  - Detection is visible in the cycle after the edge that accepts the RUN_LEN-th equal sample (latency 1 clk).
- On an edge with en=0: run_cnt and last_bit hold. x and mode are ignored. clr still acts.
- On an edge with en=1, the first matching rule applies:
  - run_cnt==0 (first sample after reset): run_cnt<=1, last_bit<=x.
  - x != last_bit: run_cnt<=1, last_bit<=x.
  - x == last_bit and run_cnt < RUN_LEN: run_cnt<=run_cnt+1.
  - x == last_bit, run_cnt==RUN_LEN, mode=0: run_cnt holds at RUN_LEN (y stays high).
  - x == last_bit, run_cnt==RUN_LEN, mode=1: run_cnt<=1 (restart; the next detection needs RUN_LEN more samples).
- Resulting y behaviour:
  - Pulse mode with en held high: y is high for exactly one clk per detection.
  - Level mode: y stays high until an opposite bit is accepted.
- mode is sampled on each accepted edge. Changing mode mid-run does not reset run_cnt.
- det_cnt:
  - A detection event is an accepted edge on which run_cnt becomes RUN_LEN from a value < RUN_LEN.
  - Level-mode hold does not count.
  - Increments by 1 per event and saturates at 2^CNT_W-1 (no wrap).
- clr and a detection event on the same edge: det_cnt<=1. With clr alone: det_cnt<=0.
- y_val = last_bit when y=1, else 0.
- All arithmetic is unsigned. run_cnt never exceeds RUN_LEN.

Test Plan:
- Level mode, default params, en=1, after reset x=0,0,0,0,1:
  - run_cnt 1,2,3,3,1.
  - y=1 after the 3rd and 4th edges, 0 after the 5th; y_val=0 while y=1.
  - det_cnt=1.
- Pulse mode, x=1 for 7 samples:
  - run_cnt 1,2,3,1,2,3,1.
  - y high for one clk after the 3rd and 6th edges, y_val=1.
  - det_cnt=2.
- en gating: x=0 with en pattern 1,0,1,0,1, and x toggled to 1 only during en=0 cycles:
  - run_cnt 1,1,2,2,3; y rises after the 5th edge.
- Async reset mid-run: assert rst between edges with run_cnt=2:
  - all outputs 0 immediately, without waiting for clk.
  - after release, x=1 accepted gives run_cnt=1 and y=0.
- Saturation and clr, CNT_W=2, pulse mode, 15 equal samples (5 events):
  - det_cnt=3 (saturated).
  - clr on the same edge as a detection gives det_cnt=1; clr alone gives 0.
- Alternating x=0,1,0,1,... for 20 samples:
  - y never asserts, run_cnt stays 1, det_cnt=0.
  - Repeat with RUN_LEN=5: the first detection appears only after the 5th equal sample.

Source files
------------

// File: rtl/run_length_detector.sv
// Serial run detector: flags RUN_LEN consecutive equal accepted samples of x.
// Supports level/pulse restart modes and keeps a saturating detection-event count.
module run_length_detector #(
  parameter int unsigned RUN_LEN = 3,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned RC_W    = $clog2(RUN_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic             mode,
  input  logic             clr,
  output logic             y,
  output logic             y_val,
  output logic [RC_W-1:0]  run_cnt,
  output logic [CNT_W-1:0] det_cnt
);

  localparam logic [RC_W-1:0]  RunMax = RC_W'(RUN_LEN);
  localparam logic [RC_W-1:0]  RunOne = RC_W'(1);
  localparam logic [CNT_W-1:0] DetMax = '1;

  logic [RC_W-1:0]  run_cnt_q, run_cnt_d;
  logic             last_bit_q, last_bit_d;
  logic [CNT_W-1:0] det_cnt_q, det_cnt_d;
  logic             det_event;

  always_comb begin
    run_cnt_d  = run_cnt_q;
    last_bit_d = last_bit_q;
    det_event  = 1'b0;
    if (en) begin
      if (run_cnt_q == '0 || x != last_bit_q) begin
        run_cnt_d  = RunOne;
        last_bit_d = x;
      end else if (run_cnt_q < RunMax) begin
        run_cnt_d = run_cnt_q + RunOne;
        // Only the transition into RunMax counts; level-mode hold does not.
        det_event = (run_cnt_d == RunMax);
      end else if (mode) begin
        run_cnt_d = RunOne;
      end
    end
  end

  always_comb begin
    det_cnt_d = det_cnt_q;
    if (clr) begin
      det_cnt_d = CNT_W'(det_event);
    end else if (det_event && det_cnt_q != DetMax) begin
      det_cnt_d = det_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt_q  <= '0;
      last_bit_q <= 1'b0;
      det_cnt_q  <= '0;
    end else begin
      run_cnt_q  <= run_cnt_d;
      last_bit_q <= last_bit_d;
      det_cnt_q  <= det_cnt_d;
    end
  end

  assign run_cnt = run_cnt_q;
  assign det_cnt = det_cnt_q;
  assign y       = (run_cnt_q == RunMax);
  assign y_val   = y & last_bit_q;

endmodule
